shift_issue_stage: RTL
======================

# shift_issue_stage

Two-deep pipelined issue/retire stage wrapped around the combinational 64-bit shifter in the datapath. It accepts a shift instruction with its operands over a valid/ready handshake. It decodes the RV64I shift encodings into the shifter's 2-bit control and 6-bit amount, and drives the shifter from a registered operand slot. It captures the shifter's result into an output register for the write-back stage.

## Interface
- `XLEN`, 64: operand/result width; the block is specified for 64 only.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  stage can accept a request this cycle.
- `instr`  in  32  instruction word.
- `rs1_val`  in  64  value to shift.
- `rs2_val`  in  64  register shift amount source; only bits [5:0] are used.
- `shift_ctl`  out  2  to shifter: 00 SLL, 01 SRL, 10 SRA, 11 pass.
- `shift_amt`  out  6  to shifter amount.
- `shift_src`  out  64  to shifter operand.
- `shift_res`  in  64  shifter output, combinational from the three outputs above.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  write-back accepts the result.
- `out_data`  out  64  result.
- `out_illegal`  out  1  the accepted instruction was not a legal shift.

## Operation
- Decode: opcode 0010011 (OP-IMM) uses amt = instr[25:20]; opcode 0110011 (OP) uses amt = rs2_val[5:0].
  - funct3 001 → SLL; needs instr[31:26]=000000 for OP-IMM, or funct7=0000000 for OP.
  - funct3 101 → SRL when instr[30]=0, SRA when instr[30]=1. All other bits of funct6/funct7 must be zero.
- Anything else is illegal. Illegal requests get ctl=11, amt=0, src=rs1_val, and the illegal flag set. The result is rs1_val unchanged.
- Slot A (operand register) holds ctl, amt, src, word flag, illegal flag and validA. The `shift_*` outputs come straight from slot A's registers.
- Slot B (result register) holds data, illegal flag and validB. `out_valid` = validB.
- Slot B loads when validA && (!validB || out_ready). The loaded data is shift_res, post-processed as described under Configuration.
- Slot A loads when in_valid && in_ready.
- `in_ready` = !validA || (slot B loads this cycle).
- A simultaneous accept into slot A and move from A to B in the same cycle is legal. Slot A then holds the new request.
- Hold rule: while `out_valid` && !`out_ready`, `out_data` and `out_illegal` are stable.
- Upstream must hold `instr`/`rs1_val`/`rs2_val` stable while `in_valid` && !`in_ready`.
- Reset (asynchronous, any cycle, including mid-transfer): validA = validB = 0. Both in-flight requests are dropped.
  - Output values after reset: shift_ctl=11, shift_amt=0, shift_src=0, out_data=0, out_illegal=0, out_valid=0.
  - `in_ready` reads 1.

## Timing
- Latency: a request accepted at edge N appears on `out_valid` after edge N+1 when unstalled.
- Throughput: one result per cycle with `out_ready` held at 1.
- With `out_ready`=0, the stage absorbs two requests, then `in_ready` drops.
- A bubble-free restart occurs the cycle `out_ready` returns.

## Configuration
- `SHIFT_WORD_OPS_EN` defined: opcodes 0011011 (OP-IMM-32) and 0111011 (OP-32) decode as SLLW/SRLW/SRAW. Behaviour of the word ops:
  - amt = {1'b0, 5-bit shamt}.
  - src is rs1_val[31:0] zero-extended for SRLW, and sign-extended for SRAW/SLLW.
  - The result is sign-extended from bit 31 when loaded into slot B.
  - For OP-IMM-32, instr[25]=1 is illegal.
- Undefined: those opcodes are illegal, and no word-flag logic exists.

## Test plan
- SLLI: rs1=0x1, instr shamt=63 → out_data 0x8000000000000000, illegal=0, out_valid one edge after accept.
- SRA register form: rs1=0xF000000000000000, rs2=0x44 (amt 4) → 0xFF00000000000000. Bits above [5:0] of rs2 are ignored.
- Backpressure: out_ready=0, three back-to-back requests → first two accepted and `in_ready`=0 on the third. Raise out_ready → results drain in order, one per cycle.
- Illegal: ADD encoding (funct3 000), rs1=0x1234 → out_data 0x1234, out_illegal=1.
- Reset asserted while both slots are valid → out_valid=0, in_ready=1, out_data=0 immediately, without waiting for a clock edge.
- With SHIFT_WORD_OPS_EN, SRLIW: rs1=0xFFFFFFFF80000000, shamt 0 → 0xFFFFFFFF80000000. SRLIW with shamt 1 → 0x0000000040000000. SLLIW with instr[25]=1 → illegal.

Source files
------------

// File: rtl/shift_issue_stage.sv
// Two-slot issue/retire stage around the external combinational 64-bit shifter.
// Optional RV64 word shifts (SLLW/SRLW/SRAW) are compiled in with `define SHIFT_WORD_OPS_EN.
module shift_issue_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic [1:0]      shift_ctl,
  output logic [5:0]      shift_amt,
  output logic [XLEN-1:0] shift_src,
  input  logic [XLEN-1:0] shift_res,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            out_illegal
);

  localparam logic [1:0] CTL_SLL  = 2'b00;
  localparam logic [1:0] CTL_SRL  = 2'b01;
  localparam logic [1:0] CTL_SRA  = 2'b10;
  localparam logic [1:0] CTL_PASS = 2'b11;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
`ifdef SHIFT_WORD_OPS_EN
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
`endif

  // Returns {legal, ctl}; funct7 must already have any shamt bit masked off.
  function automatic logic [2:0] shift_kind(input logic [2:0] funct3,
                                            input logic [6:0] funct7);
    shift_kind = {1'b0, CTL_PASS};
    if (funct3 == 3'b001 && funct7 == 7'b0000000)
      shift_kind = {1'b1, CTL_SLL};
    else if (funct3 == 3'b101 && funct7 == 7'b0000000)
      shift_kind = {1'b1, CTL_SRL};
    else if (funct3 == 3'b101 && funct7 == 7'b0100000)
      shift_kind = {1'b1, CTL_SRA};
  endfunction

`ifdef SHIFT_WORD_OPS_EN
  function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] res);
    logic signed [31:0] lo;
    lo = res[31:0];
    sext_word = {{(XLEN-32){lo[31]}}, lo};
  endfunction
`endif

  logic [2:0]      kind;
  logic [1:0]      dec_ctl;
  logic [5:0]      dec_amt;
  logic [XLEN-1:0] dec_src;
  logic            dec_ill;
`ifdef SHIFT_WORD_OPS_EN
  logic            dec_word;
  logic            word_p0;
`endif

  logic [1:0]      ctl_p0;
  logic [5:0]      amt_p0;
  logic [XLEN-1:0] src_p0;
  logic            ill_p0;
  logic            vld_p0;

  logic [XLEN-1:0] data_p1;
  logic            ill_p1;
  logic            vld_p1;

  logic            ld_a;
  logic            ld_b;
  logic [XLEN-1:0] res_fix;

  // Register numbers and destination are not this stage's concern.
  logic unused_bits;
  assign unused_bits = ^{rs2_val[XLEN-1:6], instr[19:15], instr[11:7]};

  always_comb begin
    kind    = {1'b0, CTL_PASS};
    dec_ctl = CTL_PASS;
    dec_amt = '0;
    dec_src = rs1_val;
    dec_ill = 1'b1;
`ifdef SHIFT_WORD_OPS_EN
    dec_word = 1'b0;
`endif
    case (instr[6:0])
      OPC_OP_IMM: begin
        // instr[25] is shamt[5] here, not part of funct7.
        kind = shift_kind(instr[14:12], {instr[31:26], 1'b0});
        if (kind[2]) begin
          dec_ctl = kind[1:0];
          dec_amt = instr[25:20];
          dec_ill = 1'b0;
        end
      end
      OPC_OP: begin
        kind = shift_kind(instr[14:12], instr[31:25]);
        if (kind[2]) begin
          dec_ctl = kind[1:0];
          dec_amt = rs2_val[5:0];
          dec_ill = 1'b0;
        end
      end
`ifdef SHIFT_WORD_OPS_EN
      OPC_OP_IMM_32, OPC_OP_32: begin
        // Full funct7 check also rejects OP-IMM-32 with instr[25]=1.
        kind = shift_kind(instr[14:12], instr[31:25]);
        if (kind[2]) begin
          dec_ctl  = kind[1:0];
          dec_amt  = {1'b0, (instr[6:0] == OPC_OP_32) ? rs2_val[4:0] : instr[24:20]};
          dec_src  = (kind[1:0] == CTL_SRL) ? {{(XLEN-32){1'b0}}, rs1_val[31:0]}
                                            : {{(XLEN-32){rs1_val[31]}}, rs1_val[31:0]};
          dec_word = 1'b1;
          dec_ill  = 1'b0;
        end
      end
`endif
      default: ;
    endcase
  end

  assign ld_b     = vld_p0 && (!vld_p1 || out_ready);
  assign in_ready = !vld_p0 || ld_b;
  assign ld_a     = in_valid && in_ready;

  // ---- p0: operand slot, drives the shifter directly ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0 <= 1'b0;
      ctl_p0 <= CTL_PASS;
      amt_p0 <= '0;
      src_p0 <= '0;
      ill_p0 <= 1'b0;
`ifdef SHIFT_WORD_OPS_EN
      word_p0 <= 1'b0;
`endif
    end else begin
      if (ld_a) begin
        vld_p0 <= 1'b1;
        ctl_p0 <= dec_ctl;
        amt_p0 <= dec_amt;
        src_p0 <= dec_src;
        ill_p0 <= dec_ill;
`ifdef SHIFT_WORD_OPS_EN
        word_p0 <= dec_word;
`endif
      end else if (ld_b) begin
        vld_p0 <= 1'b0;
      end
    end
  end

  assign shift_ctl = ctl_p0;
  assign shift_amt = amt_p0;
  assign shift_src = src_p0;

`ifdef SHIFT_WORD_OPS_EN
  assign res_fix = word_p0 ? sext_word(shift_res) : shift_res;
`else
  assign res_fix = shift_res;
`endif

  // ---- p1: result slot, held while write-back stalls ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ill_p1  <= 1'b0;
    end else begin
      if (ld_b) begin
        vld_p1  <= 1'b1;
        data_p1 <= res_fix;
        ill_p1  <= ill_p0;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid   = vld_p1;
  assign out_data    = data_p1;
  assign out_illegal = ill_p1;

endmodule
